pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter register and instruction-fetch front end, directly downstream of the 32-bit 2:1 next-PC mux.
//  Consumes the mux output (sequential PC+4 vs branch/jump target) as redirect_pc and issues requests to instruction memory.
//  Buffers returned words in a 2-entry queue and presents {pc, instr} to the IF/ID stage with a valid/ready handshake.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset; first fetch address.
//  DEPTH     2              Output queue depth; fixed at 2 (only value supported).
// PORTS
//  clk          in   1   Single clock; all state updates on rising edge.
//  rst_n        in   1   Asynchronous, active-low reset.
//  redirect_valid in 1   One-cycle request to change fetch stream (taken branch/jump).
//  redirect_pc  in   32  New PC, from next-PC mux data_out; bits [1:0] ignored (treated as 0).
//  imem_req     out  1   Fetch request; held high until imem_ack.
//  imem_addr    out  32  Word-aligned fetch address; stable while imem_req=1.
//  imem_ack     in   1   Memory returns imem_rdata this cycle; completes the request.
//  imem_rdata   in   32  Instruction word.
//  if_valid     out  1   Head of queue valid.
//  if_ready     in   1   IF/ID accepts head when if_valid & if_ready (pop).
//  if_instr     out  32  Instruction at head.
//  if_pc        out  32  PC of head instruction.
//  if_pc_plus4  out  32  if_pc + 4 (wraps mod 2^32); feeds next-PC mux input A.
// BEHAVIOUR
//  Reset (async assert): pc_q=RESET_PC, req_addr=RESET_PC, state=BOOT, queue empty, imem_req=0, if_valid=0,
//   if_instr=0, if_pc=0, if_pc_plus4=4. Reset mid-request abandons it; a late imem_ack while in BOOT is ignored.
//  FSM states: BOOT, FETCH, DRAIN.
//   BOOT : imem_req=0; next cycle -> FETCH (one idle cycle after reset release).
//   FETCH: imem_req=1 whenever (count + outstanding) < 2; on request start req_addr<=pc_q, outstanding=1.
//          imem_ack & no redirect: push {req_addr, imem_rdata}; pc_q<=req_addr+4; outstanding=0.
//          Back-to-back: new request may start the cycle after ack (1 fetch / 2 cycles minimum with 1-cycle memory).
//   DRAIN: entered on redirect while a request is outstanding without ack that cycle; imem_req stays 1 on old
//          req_addr; ack is discarded (no push); then -> FETCH at pc_q.
//  Redirect (any state except BOOT): queue flushed (if_valid=0 next cycle), pc_q<={redirect_pc[31:2],2'b00}.
//   Redirect + ack same cycle: data dropped, stay FETCH, next request at new pc_q.
//   Redirect in DRAIN: pc_q updated to latest target, remain DRAIN.
//   Redirect has priority over pop and push in the same cycle.
//  Queue: count 0..2; push & pop same cycle -> count unchanged, order preserved; never push when full (guaranteed by
//   req gating); pop when empty is a no-op. if_* outputs are registered head-entry fields, no combinational path
//   from imem_rdata to if_instr.
//  Latency: ack cycle N -> if_valid=1 at N+1. Redirect at N -> imem_req at new address no earlier than N+1.
//  PC arithmetic: 32-bit unsigned, +4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.
// STRUCTURE
//  Shared package cpu_pkg: RESET_PC default, fetch FSM state encoding (BOOT/FETCH/DRAIN), ADDR_W/INSTR_W=32.
//  One sub-module: fetch_queue2 (2-entry FIFO of {pc,instr}, push/pop/flush, count, registered head outputs).
//  Top holds pc_q, req_addr, outstanding flag, FSM and imem handshake.
// TESTING
//  1 Reset release, memory acks 1 cycle after req, if_ready=1 -> fetch addrs 0,4,8,C; if_pc matches, if_pc_plus4=if_pc+4.
//  2 if_ready=0 for 10 cycles -> exactly 2 entries queued, imem_req drops; raise if_ready -> pops in order, fetch resumes.
//  3 redirect_pc=32'h0000_0103 while idle -> queue flushed, next imem_addr=32'h0000_0100.
//  4 Redirect to 0x200 with outstanding req (ack 3 cycles later) -> old ack data never appears on if_instr; next addr 0x200.
//  5 Redirect and imem_ack same cycle, then second redirect in DRAIN -> only last target fetched; no stale push.
//  6 Assert rst_n=0 mid-request with queue full -> all outputs at reset values immediately; restart at RESET_PC=0xBFC0_0000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: address/instruction widths, reset PC default,
// fetch FSM encoding and the {pc, instr} queue entry.
package cpu_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Sequential PC; wraps modulo 2^32.
    function automatic logic [ADDR_W-1:0] pc_plus4(input logic [ADDR_W-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_queue2.sv
// Two-entry FIFO of fetched {pc, instr}; the head entry is held in its own
// registers so the IF/ID outputs never depend combinationally on the push data.
module fetch_queue2
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  fetch_entry_t       push_data,
    output logic [1:0]         count,
    output logic               head_valid,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [INSTR_W-1:0] head_instr,
    output logic [ADDR_W-1:0]  head_pc_plus4
);

    logic [1:0]        r_count;
    fetch_entry_t      r_head;
    fetch_entry_t      r_tail;
    logic [ADDR_W-1:0] r_head_pc4;
    logic              w_pop;

    assign w_pop = pop && (r_count != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= 2'd0;
            r_head     <= '0;
            r_tail     <= '0;
            r_head_pc4 <= 32'd4;
        end else if (flush) begin
            r_count <= 2'd0;
        end else begin
            case ({push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head     <= push_data;
                        r_head_pc4 <= pc_plus4(push_data.pc);
                    end else begin
                        r_tail <= push_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head     <= r_tail;
                    r_head_pc4 <= pc_plus4(r_tail.pc);
                    r_count    <= r_count - 2'd1;
                end
                // Simultaneous push/pop: the new word goes behind whatever remains.
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head     <= push_data;
                        r_head_pc4 <= pc_plus4(push_data.pc);
                    end else begin
                        r_head     <= r_tail;
                        r_head_pc4 <= pc_plus4(r_tail.pc);
                        r_tail     <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count         = r_count;
    assign head_valid    = (r_count != 2'd0);
    assign head_pc       = r_head.pc;
    assign head_instr    = r_head.instr;
    assign head_pc_plus4 = r_head_pc4;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch front end: one outstanding imem request at
// a time, redirect handling with a drain state, results buffered in fetch_queue2.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter int                DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [ADDR_W-1:0]  if_pc_plus4
);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc_q;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_outst;

    logic [ADDR_W-1:0] w_redir_pc;
    logic [1:0]        w_count;
    logic              w_can_req;
    logic              w_push;
    logic              w_flush;
    logic              w_unused_ok;

    assign w_redir_pc  = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign w_unused_ok = ^redirect_pc[1:0];

    // With no request outstanding, a free slot is the only gate needed.
    assign w_can_req = (int'({30'd0, w_count}) < DEPTH);
    assign w_push    = (r_state == ST_FETCH) && r_outst && imem_ack && !redirect_valid;
    assign w_flush   = redirect_valid && (r_state != ST_BOOT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_BOOT;
            r_pc_q     <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_outst    <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (redirect_valid) begin
                        r_pc_q <= w_redir_pc;
                        // An unanswered request must still be completed on the old address.
                        if (r_outst && !imem_ack) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_outst <= 1'b0;
                        end
                    end else if (r_outst && imem_ack) begin
                        r_pc_q  <= pc_plus4(r_req_addr);
                        r_outst <= 1'b0;
                    end else if (!r_outst && w_can_req) begin
                        r_req_addr <= r_pc_q;
                        r_outst    <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (redirect_valid) begin
                        r_pc_q <= w_redir_pc;
                    end
                    if (imem_ack) begin
                        r_outst <= 1'b0;
                        r_state <= ST_FETCH;
                    end
                end
                default: begin
                    r_state <= ST_BOOT;
                    r_outst <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = r_outst;
    assign imem_addr = r_req_addr;

    fetch_queue2 u_queue (
        .clk           (clk),
        .rst_n         (rst_n),
        .push          (w_push),
        .pop           (if_ready),
        .flush         (w_flush),
        .push_data     ({r_req_addr, imem_rdata}),
        .count         (w_count),
        .head_valid    (if_valid),
        .head_pc       (if_pc),
        .head_instr    (if_instr),
        .head_pc_plus4 (if_pc_plus4)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed fetch/redirect/reset scenarios,
// a budgeted instruction memory model and an IF/ID monitor popping expectations.
module tb_pc_fetch_unit;

    localparam logic [31:0] P_RST = 32'hBFC0_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    int mem_lat = 1;
    int mem_limit = 0;
    int mem_acks = 0;
    int mem_wait = 0;

    pc_fetch_unit #(.RESET_PC(P_RST), .DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hC3C3_3C3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_fetch(input logic [31:0] a);
        exp_q.push_back({a, instr_of(a)});
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired, required event never seen (t=%0t)", name, $time);
    endtask

    task automatic wait_req(input int bound);
        int k = 0;
        while (!imem_req && k < bound) begin step(); k++; end
        if (!imem_req) timeout("wait_req");
    endtask

    task automatic wait_ack(input int bound);
        int k = 0;
        while (!imem_ack && k < bound) begin step(); k++; end
        if (!imem_ack) timeout("wait_ack");
    endtask

    task automatic wait_drained(input int bound);
        int k = 0;
        while (exp_q.size() != 0 && k < bound) begin step(); k++; end
        if (exp_q.size() != 0) timeout("wait_drained");
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
    endtask

    // Instruction memory: acks after mem_lat waiting cycles, only while budget remains.
    always @(posedge clk) begin
        #1;
        if (imem_req && !imem_ack && (mem_acks < mem_limit)) begin
            if (mem_wait >= mem_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = instr_of(imem_addr);
                mem_acks++;
                mem_wait   = 0;
            end else begin
                mem_wait++;
            end
        end else begin
            imem_ack = 1'b0;
            mem_wait = 0;
        end
    end

    // IF/ID monitor: every accepted head must match the next expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && if_valid && if_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_out: got pc=%h instr=%h, required no output (t=%0t)",
                         if_pc, if_instr, $time);
            end else begin
                e = exp_q.pop_front();
                chk("out_pc", if_pc, e.pc);
                chk("out_instr", if_instr, e.instr);
                chk("out_pc_plus4", if_pc_plus4, e.pc + 32'd4);
            end
        end
    end

    initial begin
        // Reset values
        repeat (3) step();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, P_RST);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_pc4", if_pc_plus4, 32'd4);

        // Sequential fetch from the reset PC
        mem_lat  = 1;
        if_ready = 1'b1;
        for (int i = 0; i < 4; i++) expect_fetch(P_RST + 32'(4 * i));
        mem_limit += 4;
        rst_n = 1'b1;
        step();
        chk("boot_idle", {31'd0, imem_req}, 32'd0);
        step();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, P_RST);
        wait_drained(100);

        // Redirect with a request outstanding: slow ack is drained and discarded
        wait_req(20);
        chk("t4_pending_addr", imem_addr, P_RST + 32'h10);
        do_redirect(32'h0000_0200);
        chk("t4_drain_req", {31'd0, imem_req}, 32'd1);
        chk("t4_drain_addr", imem_addr, P_RST + 32'h10);
        mem_lat = 3;
        for (int i = 0; i < 3; i++) expect_fetch(32'h200 + 32'(4 * i));
        mem_limit += 4;
        wait_ack(20);
        step();
        chk("t4_after_ack_req", {31'd0, imem_req}, 32'd0);
        chk("t4_no_stale", {31'd0, if_valid}, 32'd0);
        step();
        chk("t4_new_addr", imem_addr, 32'h0000_0200);
        wait_drained(100);

        // Back-pressure: two entries queue up, requests stop, then drain in order
        wait_req(20);
        mem_lat  = 1;
        if_ready = 1'b0;
        for (int i = 0; i < 4; i++) expect_fetch(32'h20C + 32'(4 * i));
        mem_limit += 4;
        repeat (10) step();
        chk("t2_valid", {31'd0, if_valid}, 32'd1);
        chk("t2_req_dropped", {31'd0, imem_req}, 32'd0);
        chk("t2_head_pc", if_pc, 32'h0000_020C);
        chk("t2_head_instr", if_instr, instr_of(32'h20C));
        if_ready = 1'b1;
        wait_drained(100);

        // Redirect while idle with a full queue
        wait_req(20);
        if_ready = 1'b0;
        mem_limit += 2;
        repeat (8) step();
        chk("t3_idle", {31'd0, imem_req}, 32'd0);
        chk("t3_full", {31'd0, if_valid}, 32'd1);
        do_redirect(32'h0000_0103);
        chk("t3_flushed", {31'd0, if_valid}, 32'd0);
        if_ready = 1'b1;
        expect_fetch(32'h100);
        expect_fetch(32'h104);
        mem_limit += 2;
        step();
        chk("t3_req", {31'd0, imem_req}, 32'd1);
        chk("t3_addr", imem_addr, 32'h0000_0100);
        wait_drained(100);

        // Redirect coinciding with ack, then a second redirect inside DRAIN
        wait_req(20);
        mem_limit += 1;
        wait_ack(20);
        do_redirect(32'h0000_0300);
        chk("t5_dropped", {31'd0, if_valid}, 32'd0);
        step();
        chk("t5_req_300", imem_addr, 32'h0000_0300);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0400;
        step();
        redirect_pc    = 32'h0000_0500;
        step();
        redirect_valid = 1'b0;
        chk("t5_drain_addr", imem_addr, 32'h0000_0300);
        expect_fetch(32'h500);
        expect_fetch(32'h504);
        mem_limit += 3;
        wait_ack(20);
        step();
        step();
        chk("t5_last_target", imem_addr, 32'h0000_0500);
        wait_drained(100);

        // PC wrap at the top of the address space
        wait_req(20);
        do_redirect(32'hFFFF_FFF9);
        expect_fetch(32'hFFFF_FFF8);
        expect_fetch(32'hFFFF_FFFC);
        expect_fetch(32'h0000_0000);
        mem_limit += 4;
        wait_drained(100);

        // Asynchronous reset mid-request with queue at capacity
        wait_req(20);
        if_ready = 1'b0;
        mem_limit += 1;
        wait_ack(20);
        step();
        step();
        chk("t6_pending", {31'd0, imem_req}, 32'd1);
        mem_limit += 1;
        wait_ack(20);
        rst_n = 1'b0;
        #1;
        chk("t6_req", {31'd0, imem_req}, 32'd0);
        chk("t6_valid", {31'd0, if_valid}, 32'd0);
        chk("t6_instr", if_instr, 32'd0);
        chk("t6_pc", if_pc, 32'd0);
        chk("t6_pc4", if_pc_plus4, 32'd4);
        chk("t6_addr", imem_addr, P_RST);
        step();
        step();
        if_ready = 1'b1;
        expect_fetch(P_RST);
        expect_fetch(P_RST + 32'd4);
        mem_limit += 2;
        rst_n = 1'b1;
        step();
        chk("t6_boot_idle", {31'd0, imem_req}, 32'd0);
        step();
        chk("t6_restart_addr", imem_addr, P_RST);
        wait_drained(100);
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
